// File: rtl/microcpu_pkg.sv
// Shared microcpu datapath constants.
// Default register-file geometry and the hardwired zero index.
package microcpu_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Load-pending scoreboard for the register file.
// One bit per register; set by load issue, cleared by memory write-back.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_issue,
    input  logic [ADDR_W-1:0]        ld_dest,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pending
);
    import microcpu_pkg::*;

    logic [NUM_REGS-1:0] r_pending;
    logic                w_ld_zero;

    assign w_ld_zero = (ZERO_REG != 0) && (ld_dest == ADDR_W'(ZERO_IDX));

    // Set is written last so a new load beats its predecessor's completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            if (mem_we)
                r_pending[mem_dest] <= 1'b0;
            if (ld_issue && !w_ld_zero)
                r_pending[ld_dest] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_pending[i] = r_pending[w_addr]
                            && !(mem_we && mem_dest == w_addr);
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with ALU/memory write-back and bypass.
// Memory write-back wins same-index collisions; loads tracked by scoreboard.
module reg_file_mp #(
    parameter int DATA_W   = microcpu_pkg::DATA_W,
    parameter int NUM_REGS = microcpu_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     alu_we,
    input  logic [ADDR_W-1:0]        alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_dest,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     ld_issue,
    input  logic [ADDR_W-1:0]        ld_dest,
    output logic                     wr_conflict
);
    import microcpu_pkg::*;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_conflict;
    logic              w_alu_zero;
    logic              w_mem_zero;
    logic              w_same_dest;

    assign w_alu_zero  = (ZERO_REG != 0) && (alu_dest == ADDR_W'(ZERO_IDX));
    assign w_mem_zero  = (ZERO_REG != 0) && (mem_dest == ADDR_W'(ZERO_IDX));
    assign w_same_dest = alu_we && mem_we && (alu_dest == mem_dest)
                      && (alu_dest != ADDR_W'(ZERO_IDX));

    // Memory write is issued last so it overrides the younger ALU result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
            r_conflict <= 1'b0;
        end else begin
            if (alu_we && !w_alu_zero)
                r_regs[alu_dest] <= alu_data;
            if (mem_we && !w_mem_zero)
                r_regs[mem_dest] <= mem_data;
            r_conflict <= w_same_dest;
        end
    end

    assign wr_conflict = r_conflict;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_mem_hit;
        logic              w_alu_hit;
        assign w_addr    = rd_addr[i*ADDR_W +: ADDR_W];
        assign w_zero    = (ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_IDX));
        assign w_mem_hit = mem_we && (mem_dest == w_addr);
        assign w_alu_hit = alu_we && (alu_dest == w_addr);
        assign rd_data[i*DATA_W +: DATA_W] =
            w_zero    ? '0       :
            w_mem_hit ? mem_data :
            w_alu_hit ? alu_data :
                        r_regs[w_addr];
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_issue   (ld_issue),
        .ld_dest    (ld_dest),
        .mem_we     (mem_we),
        .mem_dest   (mem_dest),
        .rd_addr    (rd_addr),
        .rd_pending (rd_pending)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default instance plus a
// 4-port, 16-bit, no-zero-register instance driven in lockstep.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we, mem_we, ld_issue;
    logic [4:0]  alu_dest, mem_dest, ld_dest;
    logic [31:0] alu_data, mem_data;
    logic [4:0]  ra [4];

    logic [9:0]  a_addr;
    logic [63:0] a_data;
    logic [1:0]  a_pend;
    logic        a_conf;
    logic [19:0] b_addr;
    logic [63:0] b_data;
    logic [3:0]  b_pend;
    logic        b_conf;

    assign a_addr = {ra[1], ra[0]};
    assign b_addr = {ra[3], ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    reg_file_mp u_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_addr), .rd_data(a_data), .rd_pending(a_pend),
        .alu_we(alu_we), .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_we(mem_we), .mem_dest(mem_dest), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_dest(ld_dest),
        .wr_conflict(a_conf)
    );

    reg_file_mp #(.DATA_W(16), .NUM_RD(4), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_addr), .rd_data(b_data), .rd_pending(b_pend),
        .alu_we(alu_we), .alu_dest(alu_dest), .alu_data(alu_data[15:0]),
        .mem_we(mem_we), .mem_dest(mem_dest), .mem_data(mem_data[15:0]),
        .ld_issue(ld_issue), .ld_dest(ld_dest),
        .wr_conflict(b_conf)
    );

    typedef struct packed {
        logic [1:0][31:0] ad;
        logic [1:0]       ap;
        logic             ac;
        logic [3:0][15:0] bd;
        logic [3:0]       bp;
        logic             bc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: index 0 = default instance, 1 = 16-bit, no zero reg.
    logic [31:0] mreg  [2][32];
    logic        mpend [2][32];
    logic        mconf [2];

    function automatic logic [31:0] msk(int m);
        return (m == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] mrd(int m, logic [4:0] a);
        if (m == 0 && a == 0) return 32'h0;
        if (mem_we && mem_dest == a) return mem_data & msk(m);
        if (alu_we && alu_dest == a) return alu_data & msk(m);
        return mreg[m][a];
    endfunction

    function automatic logic mpd(int m, logic [4:0] a);
        return mpend[m][a] && !(mem_we && mem_dest == a);
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 32; k++) begin
                mreg[m][k]  = 32'h0;
                mpend[m][k] = 1'b0;
            end
            mconf[m] = 1'b0;
        end
    endtask

    task automatic mupd();
        for (int m = 0; m < 2; m++) begin
            if (alu_we && !(m == 0 && alu_dest == 0))
                mreg[m][alu_dest] = alu_data & msk(m);
            if (mem_we && !(m == 0 && mem_dest == 0))
                mreg[m][mem_dest] = mem_data & msk(m);
            if (mem_we) mpend[m][mem_dest] = 1'b0;
            if (ld_issue && !(m == 0 && ld_dest == 0))
                mpend[m][ld_dest] = 1'b1;
            mconf[m] = alu_we && mem_we && alu_dest == mem_dest
                    && alu_dest != 0;
        end
    endtask

    task automatic push_exp();
        exp_t        e;
        logic [31:0] t;
        for (int p = 0; p < 2; p++) begin
            e.ad[p] = mrd(0, ra[p]);
            e.ap[p] = mpd(0, ra[p]);
        end
        for (int p = 0; p < 4; p++) begin
            t       = mrd(1, ra[p]);
            e.bd[p] = t[15:0];
            e.bp[p] = mpd(1, ra[p]);
        end
        e.ac = mconf[0];
        e.bc = mconf[1];
        q.push_back(e);
    endtask

    task automatic step(input logic aw, input logic [4:0] ad,
                        input logic [31:0] adt,
                        input logic mw, input logic [4:0] md,
                        input logic [31:0] mdt,
                        input logic li, input logic [4:0] ld,
                        input logic [4:0] r0, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] r3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alu_we = aw; alu_dest = ad; alu_data = adt;
        mem_we = mw; mem_dest = md; mem_data = mdt;
        ld_issue = li; ld_dest = ld;
        ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
        push_exp();
        mupd();
    endtask

    task automatic idle(input logic [4:0] r);
        step(0, 0, 0, 0, 0, 0, 0, 0, r, r, r, r);
    endtask

    // Asynchronous clear observed mid-cycle, before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        alu_we = 0; mem_we = 0; ld_issue = 0;
        mreset();
        push_exp();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("a_rd_data[%0d]", p),
                        a_data[p*32 +: 32], e.ad[p]);
                    chk($sformatf("a_rd_pending[%0d]", p),
                        {31'h0, a_pend[p]}, {31'h0, e.ap[p]});
                end
                for (int p = 0; p < 4; p++) begin
                    chk($sformatf("b_rd_data[%0d]", p),
                        {16'h0, b_data[p*16 +: 16]}, {16'h0, e.bd[p]});
                    chk($sformatf("b_rd_pending[%0d]", p),
                        {31'h0, b_pend[p]}, {31'h0, e.bp[p]});
                end
                chk("a_wr_conflict", {31'h0, a_conf}, {31'h0, e.ac});
                chk("b_wr_conflict", {31'h0, b_conf}, {31'h0, e.bc});
            end
        end
    end

    initial begin : driver
        logic [4:0] d0, d1, r0, r1, r2, r3;
        rst_n = 1'b0;
        alu_we = 0; mem_we = 0; ld_issue = 0;
        alu_dest = 0; mem_dest = 0; ld_dest = 0;
        alu_data = 0; mem_data = 0;
        for (int p = 0; p < 4; p++) ra[p] = 5'd0;
        mreset();

        do_reset();
        // write/readback with bypass, then from storage
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5, 5, 4);
        idle(5);
        // dual write to 7: memory data wins, conflict for one cycle
        step(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7, 7, 7);
        idle(7);
        idle(7);
        // zero register
        step(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0);
        // load-use
        step(0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 3, 3);
        idle(3);
        idle(3);
        step(0, 0, 0, 1, 3, 32'hCAFE0003, 0, 0, 3, 3, 3, 3);
        idle(3);
        // set/clear race on 9
        step(0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 9, 9);
        step(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 9, 9, 9);
        idle(9);
        step(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 9, 9, 9);
        idle(9);
        // preload, then reset mid-cycle
        for (int k = 1; k < 8; k++)
            step(1, 5'(k), $urandom, 1, 5'(k + 8), $urandom,
                 1, 5'(k + 16), 5'(k), 5'(k + 8), 5'(k + 16), 0);
        do_reset();
        idle(3);

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                d0 = 5'($urandom_range(0, 31));
                d1 = ($urandom_range(0, 3) == 0) ? d0
                                                 : 5'($urandom_range(0, 31));
                r0 = $urandom_range(0, 1) ? d0 : 5'($urandom_range(0, 31));
                r1 = $urandom_range(0, 1) ? d1 : 5'($urandom_range(0, 31));
                r2 = 5'($urandom_range(0, 31));
                r3 = $urandom_range(0, 3) == 0 ? 5'd0 : d1;
                step(1'($urandom_range(0, 1)), d0, $urandom,
                     1'($urandom_range(0, 1)), d1, $urandom,
                     1'($urandom_range(0, 2) == 0),
                     $urandom_range(0, 1) ? r0 : 5'($urandom_range(0, 31)),
                     r0, r1, r2, r3);
            end
        end

        repeat (3) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
